tx_arbiter_8: RTL and testbench

TX_ARBITER_8 -- requirements
Module: tx_arbiter_8

---
 rtl/lvds_pkg.sv | 25 ++
 rtl/rr_pick_8.sv | 40 ++++
 rtl/tx_arbiter_8.sv | 111 +++++++++++
 tb/tb_tx_arbiter_8.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvds_pkg
// Description : Shared definitions for the LVDS transmit arbiter slice.
//               Holds the channel count, the select-index width, the
//               arbiter state encoding and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lvds_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Binary channel index to one-hot grant vector.
  function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_8
// Description : Combinational round-robin picker for 8 requesters. Searches
//               upward from (ptr+1) mod 8, wrapping 7 -> 0, and returns the
//               first requesting channel.
// Ports       : i_req    [7:0] per-channel request
//               i_ptr    [2:0] last granted channel
//               o_winner [2:0] selected channel index (0 when none)
//               o_any          at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_8
  import lvds_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [SEL_W-1:0]  o_winner,
  output logic              o_any
);

  // Walk the offsets from farthest (8, i.e. ptr itself) to nearest (1); the
  // last hit therefore is the closest requester after ptr. The 3-bit add
  // wraps naturally modulo 8.
  always_comb begin
    logic [SEL_W-1:0] w_idx;
    w_idx    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_idx = i_ptr + SEL_W'(i);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tx_arbiter_8
// Description : Round-robin transmit arbiter for 8 channels feeding one
//               serializer. Holds a grant for a whole packet, releases on
//               last beat, on channel abandonment, or after MAX_BEATS
//               accepted beats (with a truncation pulse). One IDLE cycle
//               always separates consecutive grants.
// Ports       : i_clk          clock, rising edge
//               i_arst_n       asynchronous active-low reset
//               i_req    [7:0] per-channel beat pending
//               i_last         last-beat flag of the selected channel
//               i_ready        serializer accepts a beat this cycle
//               o_sel    [2:0] binary index for the downstream data mux
//               o_gnt    [7:0] one-hot grant, zero when idle
//               o_valid        selected channel presents a beat
//               o_trunc        grant force-released by MAX_BEATS
// Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter_8
  import lvds_pkg::*;
#(
  parameter int MAX_BEATS = 64
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [SEL_W-1:0]  o_sel,
  output logic [NUM_CH-1:0] o_gnt,
  output logic              o_valid,
  output logic              o_trunc
);

  localparam logic [7:0] c_last_cnt = 8'(MAX_BEATS - 1);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [NUM_CH-1:0] r_gnt;
  logic [SEL_W-1:0] r_ptr;
  logic [7:0]       r_cnt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_sel_req;
  logic             w_valid;
  logic             w_accept;
  logic             w_at_max;
  logic             w_release;

  rr_pick_8 u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_sel_req = i_req[r_sel];
  assign w_valid   = (r_state == ARB_GRANT) && w_sel_req;
  assign w_accept  = w_valid && i_ready;
  // The beat being accepted now is number MAX_BEATS when r_cnt already
  // holds MAX_BEATS-1 completed beats.
  assign w_at_max  = (r_cnt == c_last_cnt);

  // A dropped request can never coincide with an accept (valid needs the
  // request), so the three release causes never overlap ambiguously.
  assign w_release = (w_accept && (i_last || w_at_max)) || !w_sel_req;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_ptr   <= '1;   // ptr = 7 so channel 0 is searched first
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_GRANT;
            r_sel   <= w_winner;
            r_gnt   <= sel_to_onehot(w_winner);
            r_cnt   <= '0;
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= r_sel;
          end else if (w_accept && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_gnt   = r_gnt;
  assign o_valid = w_valid;
  // Truncation only when the limit, not the packet end, caused the release.
  assign o_trunc = w_accept && w_at_max && !i_last;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_arbiter_8
// Description : Self-checking bench for tx_arbiter_8 (MAX_BEATS = 4).
//               Stimulus pushes the expected channel/trunc of every beat it
//               intends to have accepted; a negedge monitor pops and compares
//               whenever a beat is accepted. Registered outputs are also
//               checked directly after the relevant clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter_8;

  typedef struct packed {
    logic [2:0] sel;
    logic       trunc;
  } exp_t;

  logic       clk;
  logic       arst_n;
  logic [7:0] req;
  logic       last;
  logic       ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       trunc;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  tx_arbiter_8 #(.MAX_BEATS(4)) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .i_req    (req),
    .i_last   (last),
    .i_ready  (ready),
    .o_sel    (sel),
    .o_gnt    (gnt),
    .o_valid  (valid),
    .o_trunc  (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the next expectation.
  always @(negedge clk) begin
    if (arst_n && valid && ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got sel %0d with no beat expected (t=%0t)", sel, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("beat_sel",   32'(sel),   32'(e.sel));
        check("beat_gnt",   32'(gnt),   32'(8'h01 << e.sel));
        check("beat_trunc", 32'(trunc), 32'(e.trunc));
      end
    end
  end

  // One clock cycle: drive inputs, optionally check o_valid mid-cycle, then
  // return just after the rising edge. ev < 0 skips the valid check.
  task automatic cyc(input logic [7:0] r, input logic l, input logic rdy, input int ev);
    req   = r;
    last  = l;
    ready = rdy;
    #2;
    if (ev >= 0) check("valid", 32'(valid), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  // A cycle in which a beat from channel s must be accepted.
  task automatic beat(input logic [7:0] r, input logic l, input logic [2:0] s, input logic t);
    exp_t e;
    e.sel   = s;
    e.trunc = t;
    q.push_back(e);
    cyc(r, l, 1'b1, 1);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),   32'h00);
    check("rst_sel",   32'(sel),   32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_trunc", 32'(trunc), 32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    req    = 8'h00;
    last   = 1'b0;
    ready  = 1'b0;
    #3;
    check("por_gnt",   32'(gnt),   32'h00);
    check("por_sel",   32'(sel),   32'h0);
    check("por_valid", 32'(valid), 32'h0);
    check("por_trunc", 32'(trunc), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    cyc(8'h00, 1'b0, 1'b1, 0);
    check("idle_gnt", 32'(gnt), 32'h00);

    // Single requester, 3-beat packet on channel 0.
    cyc(8'h01, 1'b0, 1'b1, 0);
    check("t1_gnt", 32'(gnt), 32'h01);
    check("t1_sel", 32'(sel), 32'h0);
    beat(8'h01, 1'b0, 3'd0, 1'b0);
    beat(8'h01, 1'b0, 3'd0, 1'b0);
    beat(8'h01, 1'b1, 3'd0, 1'b0);
    check("t1_rel_gnt", 32'(gnt), 32'h00);
    check("t1_rel_sel", 32'(sel), 32'h0);

    // All requesting, 1-beat packets: 0..7,0 with one idle cycle each.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc(8'hFF, 1'b0, 1'b1, 0);
      check("rr_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
      beat(8'hFF, 1'b1, 3'(k % 8), 1'b0);
      check("rr_gap_gnt", 32'(gnt), 32'h00);
    end

    // Set ptr to 5, then 5 and 0 both request: wrap picks 0.
    cyc(8'h20, 1'b0, 1'b1, 0);
    check("p5_sel", 32'(sel), 32'h5);
    beat(8'h20, 1'b1, 3'd5, 1'b0);
    cyc(8'h21, 1'b0, 1'b1, 0);
    check("wrap_sel", 32'(sel), 32'h0);
    check("wrap_gnt", 32'(gnt), 32'h01);
    beat(8'h21, 1'b1, 3'd0, 1'b0);

    // MAX_BEATS without last: truncation on beat 4.
    cyc(8'h02, 1'b0, 1'b1, 0);
    check("mx_gnt", 32'(gnt), 32'h02);
    beat(8'h02, 1'b0, 3'd1, 1'b0);
    beat(8'h02, 1'b0, 3'd1, 1'b0);
    beat(8'h02, 1'b0, 3'd1, 1'b0);
    beat(8'h02, 1'b0, 3'd1, 1'b1);
    check("mx_rel_gnt", 32'(gnt), 32'h00);
    cyc(8'h00, 1'b0, 1'b1, 0);
    check("mx_trunc_after", 32'(trunc), 32'h0);

    // Last coincides with beat 4: normal end, no truncation.
    cyc(8'h04, 1'b0, 1'b1, 0);
    beat(8'h04, 1'b0, 3'd2, 1'b0);
    beat(8'h04, 1'b0, 3'd2, 1'b0);
    beat(8'h04, 1'b0, 3'd2, 1'b0);
    beat(8'h04, 1'b1, 3'd2, 1'b0);
    check("lm_rel_gnt", 32'(gnt), 32'h00);

    // Channel 2 with stalls, then abandoned after 2 beats.
    cyc(8'h04, 1'b0, 1'b1, 0);
    check("st_gnt", 32'(gnt), 32'h04);
    beat(8'h04, 1'b0, 3'd2, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1);
    cyc(8'h04, 1'b0, 1'b0, 1);
    beat(8'h04, 1'b0, 3'd2, 1'b0);   // 4th beat if stalls had counted
    check("st_hold_gnt", 32'(gnt), 32'h04);
    cyc(8'h00, 1'b0, 1'b1, 0);       // abandon
    check("ab_gnt", 32'(gnt), 32'h00);
    check("ab_trunc", 32'(trunc), 32'h0);
    cyc(8'hFF, 1'b0, 1'b1, 0);       // ptr = 2 so channel 3 wins
    check("ab_ptr_sel", 32'(sel), 32'h3);
    beat(8'hFF, 1'b1, 3'd3, 1'b0);

    // Reset mid-grant on channel 6.
    cyc(8'h40, 1'b0, 1'b1, 0);
    check("r6_gnt", 32'(gnt), 32'h40);
    beat(8'h40, 1'b0, 3'd6, 1'b0);
    req   = 8'hFF;
    ready = 1'b1;
    last  = 1'b0;
    #1;
    do_reset();
    cyc(8'hFF, 1'b0, 1'b1, 0);
    check("r6_next_sel", 32'(sel), 32'h0);
    check("r6_next_gnt", 32'(gnt), 32'h01);
    beat(8'hFF, 1'b1, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 0);

    check("sb_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
